// File: rtl/divisor_secuencial_if.sv
// Command/operand/result bundle for divisor_secuencial.
// Optional div_cero result flag is present only when DIVISOR_DIVCERO_EN is defined.
interface divisor_secuencial_if #(
  parameter int ANCHO = 8
);
  // Control is a one-cycle command sampled on every rising edge; there is no ready.
  // A start (4'b0100) is accepted only while busy==0 (the done cycle counts as idle).
  // done pulses for one cycle when cociente/residuo carry a new result.
  logic [3:0]       Control;
  logic [ANCHO-1:0] dividendo;
  logic [ANCHO-1:0] divisor;
  logic [ANCHO-1:0] cociente;
  logic [ANCHO-1:0] residuo;
  logic             busy;
  logic             done;
`ifdef DIVISOR_DIVCERO_EN
  logic             div_cero;

  modport master (output Control, dividendo, divisor,
                  input  cociente, residuo, busy, done, div_cero);
  modport slave  (input  Control, dividendo, divisor,
                  output cociente, residuo, busy, done, div_cero);
`else
  modport master (output Control, dividendo, divisor,
                  input  cociente, residuo, busy, done);
  modport slave  (input  Control, dividendo, divisor,
                  output cociente, residuo, busy, done);
`endif
endinterface

// File: rtl/divisor_secuencial.sv
// Sequential restoring unsigned divider, one quotient bit per clock (ANCHO steps).
// Optional macro DIVISOR_DIVCERO_EN: flags divide-by-zero and answers it in one cycle.
module divisor_secuencial #(
  parameter int ANCHO = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  divisor_secuencial_if.slave   bus,
  output logic                  estado_dbg
);
  localparam int              CW        = $clog2(ANCHO);
  localparam logic [CW-1:0]   ULTIMO    = CW'(ANCHO - 1);
  localparam logic [3:0]      CMD_START = 4'b0100;
  localparam logic [3:0]      CMD_CLEAR = 4'b0010;

  typedef enum logic {IDLE, RUN} estado_t;

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] q_q, q_d;
  logic [ANCHO-1:0] d_q, d_d;
  logic [ANCHO:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ANCHO-1:0] coc_q, coc_d;
  logic [ANCHO-1:0] res_q, res_d;
  logic             done_q, done_d;
`ifdef DIVISOR_DIVCERO_EN
  logic             cero_q, cero_d;
  logic             pend_q, pend_d;
`endif

  logic [ANCHO:0]   r_sh;
  logic [ANCHO:0]   r_st;
  logic [ANCHO-1:0] q_st;
  logic             ge;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    r_sh = {r_q[ANCHO-1:0], q_q[ANCHO-1]};
    ge   = (r_sh >= {1'b0, d_q});
    r_st = ge ? (r_sh - {1'b0, d_q}) : r_sh;
    q_st = {q_q[ANCHO-2:0], ge};
  end

  always_comb begin
    estado_d = estado_q;
    q_d      = q_q;
    d_d      = d_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    coc_d    = coc_q;
    res_d    = res_q;
    done_d   = 1'b0;
`ifdef DIVISOR_DIVCERO_EN
    cero_d   = cero_q;
    pend_d   = pend_q;
`endif
    if (bus.Control == CMD_CLEAR) begin
      estado_d = IDLE;
      coc_d    = '0;
      res_d    = '0;
      cnt_d    = '0;
`ifdef DIVISOR_DIVCERO_EN
      cero_d   = 1'b0;
      pend_d   = 1'b0;
`endif
    end else begin
      case (estado_q)
        IDLE: begin
          if (bus.Control == CMD_START) begin
            q_d      = bus.dividendo;
            d_d      = bus.divisor;
            r_d      = '0;
            cnt_d    = '0;
            estado_d = RUN;
`ifdef DIVISOR_DIVCERO_EN
            cero_d   = 1'b0;
            pend_d   = (bus.divisor == '0);
`endif
          end
        end
        RUN: begin
          q_d   = q_st;
          r_d   = r_st;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ULTIMO) begin
            coc_d    = q_st;
            res_d    = r_st[ANCHO-1:0];
            done_d   = 1'b1;
            cnt_d    = '0;
            estado_d = IDLE;
          end
`ifdef DIVISOR_DIVCERO_EN
          // Zero divisor: q_q still holds the untouched dividend.
          if (pend_q) begin
            q_d      = q_q;
            r_d      = r_q;
            cnt_d    = '0;
            coc_d    = '1;
            res_d    = q_q;
            done_d   = 1'b1;
            cero_d   = 1'b1;
            pend_d   = 1'b0;
            estado_d = IDLE;
          end
`endif
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      coc_q    <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
`ifdef DIVISOR_DIVCERO_EN
      cero_q   <= 1'b0;
      pend_q   <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      q_q      <= q_d;
      d_q      <= d_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      coc_q    <= coc_d;
      res_q    <= res_d;
      done_q   <= done_d;
`ifdef DIVISOR_DIVCERO_EN
      cero_q   <= cero_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign bus.cociente = coc_q;
  assign bus.residuo  = res_q;
  assign bus.busy     = (estado_q == RUN);
  assign bus.done     = done_q;
`ifdef DIVISOR_DIVCERO_EN
  assign bus.div_cero = cero_q;
`endif
  assign estado_dbg   = (estado_q == RUN);
endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed scoreboard bench for divisor_secuencial (ANCHO=8); honours DIVISOR_DIVCERO_EN.
module tb_divisor_secuencial;
  localparam int         A         = 8;
  localparam int         W         = 2 * A + 1;
  localparam logic [3:0] CMD_START = 4'b0100;
  localparam logic [3:0] CMD_CLEAR = 4'b0010;
  localparam logic [3:0] CMD_NOP   = 4'b0000;
`ifdef DIVISOR_DIVCERO_EN
  localparam int         LAT0      = 1;
`else
  localparam int         LAT0      = A;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic estado_dbg;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];

  divisor_secuencial_if #(.ANCHO(A)) bus_if ();

  divisor_secuencial #(.ANCHO(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if.slave),
    .estado_dbg (estado_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus_if.done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        logic [W-1:0] e;
        int           c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("cociente", int'(bus_if.cociente), int'(e[2*A-1:A]));
        check("residuo", int'(bus_if.residuo), int'(e[A-1:0]));
        check("done_cycle", cyc, c);
        check("busy_at_done", int'(bus_if.busy), 0);
`ifdef DIVISOR_DIVCERO_EN
        check("div_cero", int'(bus_if.div_cero), int'(e[W-1]));
`endif
      end
    end
  end

  // Driver tasks (called at a negedge)
  task automatic launch(input logic [A-1:0] a, input logic [A-1:0] b,
                        input logic [A-1:0] qc, input logic [A-1:0] rc,
                        input int lat, input bit push);
    bus_if.Control   = CMD_START;
    bus_if.dividendo = a;
    bus_if.divisor   = b;
    if (push) begin
      exp_q.push_back({(b == '0), qc, rc});
      cyc_q.push_back(cyc + 1 + lat);
    end
    @(negedge clk);
    bus_if.Control = CMD_NOP;
    #1;
    check("busy_after_accept", int'(bus_if.busy), 1);
  endtask

  task automatic wait_done();
    int i = 0;
    while (!bus_if.done && i < 30) begin
      @(negedge clk);
      i++;
    end
    if (!bus_if.done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles");
    end
  endtask

  task automatic idle(input int n);
    bus_if.Control = CMD_NOP;
    repeat (n) @(negedge clk);
  endtask

  logic [A-1:0] va[5] = '{8'd200, 8'd250, 8'd0, 8'd7,   8'd255};
  logic [A-1:0] vb[5] = '{8'd7,   8'd16,  8'd5, 8'd255, 8'd255};
  logic [A-1:0] vq[5] = '{8'd28,  8'd15,  8'd0, 8'd0,   8'd1};
  logic [A-1:0] vr[5] = '{8'd4,   8'd10,  8'd0, 8'd7,   8'd0};

  initial begin
    bus_if.Control   = CMD_NOP;
    bus_if.dividendo = '0;
    bus_if.divisor   = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_cociente", int'(bus_if.cociente), 0);
    check("reset_residuo", int'(bus_if.residuo), 0);
    check("reset_busy", int'(bus_if.busy), 0);
    check("reset_done", int'(bus_if.done), 0);
    check("reset_estado", int'(estado_dbg), 0);
    rst = 1'b0;
    idle(2);

    // Reset in the middle of a divide
    launch(8'd200, 8'd7, 8'd0, 8'd0, A, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_if.Control = CMD_START;
    repeat (2) @(negedge clk);
    #1;
    check("midrun_rst_busy", int'(bus_if.busy), 0);
    check("midrun_rst_cociente", int'(bus_if.cociente), 0);
    check("midrun_rst_residuo", int'(bus_if.residuo), 0);
    check("midrun_rst_estado", int'(estado_dbg), 0);
    rst = 1'b0;
    idle(12);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      launch(va[i], vb[i], vq[i], vr[i], A, 1'b1);
      #1;
      wait_done();
      @(negedge clk);
      #1;
      check("busy_after_done", int'(bus_if.busy), 0);
      check("done_one_cycle", int'(bus_if.done), 0);
      idle(1);
    end

    // Back-to-back: second start issued in the done cycle
    launch(8'd255, 8'd1, 8'd255, 8'd0, A, 1'b1);
    wait_done();
    launch(8'd5, 8'd9, 8'd0, 8'd5, A, 1'b1);
    wait_done();
    idle(3);

    // Start held during RUN with moving operands
    bus_if.Control   = CMD_START;
    bus_if.dividendo = 8'd13;
    bus_if.divisor   = 8'd3;
    exp_q.push_back({1'b0, 8'd4, 8'd1});
    cyc_q.push_back(cyc + 1 + A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.dividendo = 8'(8'd90 + i);
      bus_if.divisor   = 8'(i);
    end
    bus_if.Control = CMD_NOP;
    wait_done();
    idle(12);

    // Clear at step 4 of 100/10
    launch(8'd100, 8'd10, 8'd0, 8'd0, A, 1'b0);
    repeat (3) @(negedge clk);
    bus_if.Control = CMD_CLEAR;
    @(negedge clk);
    #1;
    check("clear_busy", int'(bus_if.busy), 0);
    check("clear_cociente", int'(bus_if.cociente), 0);
    check("clear_residuo", int'(bus_if.residuo), 0);
    check("clear_done", int'(bus_if.done), 0);
    idle(10);

    // Divide by zero
    launch(8'd77, 8'd0, 8'd255, 8'd77, LAT0, 1'b1);
    wait_done();
    idle(4);

    check("pending_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
